pu_row_loader: RTL

- Upstream stage of the img2col processing-unit vector.
- Accepts a two-pixel-per-beat stream from the AXI side and writes it row by row into the PU register files by driving the per-row start strobes, new1/new2 and adrs_in1/adrs_in2.
- After a full frame is loaded, issues the round pulses that make the PUs shift and emit columns.
- Signals done and reports framing errors.

---
 rtl/pu_row_loader_pkg.sv | 25 ++
 rtl/pu_row_loader_if.sv | 21 ++
 rtl/pu_row_loader_addr_cnt.sv | 68 ++++++
 rtl/pu_row_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pu_row_loader_pkg.sv
// img2col_pkg: definitions shared by the row loader and the PU vector.
//   state_e          - loader FSM states (IDLE, LOAD, ROUND, DONE)
//   *_DEF            - default geometry shared with the PU vector
//   beats_per_frame  - number of two-pixel beats that fill every PU register
package img2col_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int ROW_DEF         = 28;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ADDRESS_NUM_DEF = 5;
    localparam int REG_NUM_DEF     = 20;
    localparam int SHIFTS_DEF      = 24;

    // Two pixels land per beat, so a frame is half the total register count.
    function automatic int beats_per_frame(input int rows, input int regs);
        return (rows * regs) / 2;
    endfunction

endpackage

// File: rtl/pu_row_loader_if.sv
// pu_row_loader_if: two-pixel-per-beat pixel stream.
//   s_valid  - beat valid (upstream)
//   s_ready  - beat accepted when s_valid & s_ready (loader)
//   s_data1  - even-column pixel
//   s_data2  - odd-column pixel
//   s_last   - final beat of the frame
// master = upstream producer, slave = row loader.
interface pu_row_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data1;
    logic [DATA_WIDTH-1:0] s_data2;
    logic                  s_last;

    modport master (output s_valid, output s_data1, output s_data2, output s_last,
                    input  s_ready);
    modport slave  (input  s_valid, input  s_data1, input  s_data2, input  s_last,
                    output s_ready);
endinterface

// File: rtl/pu_row_loader_addr_cnt.sv
// pu_addr_cnt: row/column write pointer for the PU register files.
//   clk, nrst   - clock, asynchronous active-high reset
//   clr         - return to row 0 / column 0
//   adv         - one two-register write happened; step the pointer
//   row         - PU currently being filled
//   col         - even register address within that PU
//   frame_last  - pointer sits on the final write of the frame
module pu_addr_cnt
    import img2col_pkg::*;
#(
    parameter int ROW         = ROW_DEF,
    parameter int ADDRESS_NUM = ADDRESS_NUM_DEF,
    parameter int REG_NUM     = REG_NUM_DEF,
    parameter int ROW_W       = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   clr,
    input  logic                   adv,
    output logic [ROW_W-1:0]       row,
    output logic [ADDRESS_NUM-1:0] col,
    output logic                   frame_last
);

    logic [ROW_W-1:0]       row_q, row_d;
    logic [ADDRESS_NUM-1:0] col_q, col_d;
    logic                   col_wrap_s;
    logic                   row_wrap_s;

    assign col_wrap_s = (col_q == ADDRESS_NUM'(REG_NUM - 2));
    assign row_wrap_s = (row_q == ROW_W'(ROW - 1));

    // Next pointer: column steps by two, wraps into the next row; row wraps at frame end.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_wrap_s) begin
                col_d = '0;
                row_d = row_wrap_s ? '0 : (row_q + ROW_W'(1));
            end else begin
                col_d = col_q + ADDRESS_NUM'(2);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row        = row_q;
    assign col        = col_q;
    assign frame_last = col_wrap_s & row_wrap_s;

endmodule

// File: rtl/pu_row_loader.sv
// pu_row_loader: writes a two-pixel stream row by row into the PU register
// files, then issues SHIFTS round pulses, then pulses done.
//   clk, nrst            - clock, asynchronous active-high reset
//   go                   - frame start request (accepted only when idle)
//   s_if (slave)         - pixel stream; s_ready is combinational (LOAD only)
//   start                - one-hot write strobe to PU[row]
//   round                - all-ones shift pulse to every PU
//   new1/new2            - pixel pair for adrs_in1/adrs_in2
//   adrs_in1/adrs_in2    - even/odd register address
//   busy, done, err      - frame in progress, end-of-frame pulse, sticky framing error
// Build option PU_ROW_LOADER_ZERO_PAD_EN: an early s_last zero-fills the rest
// of the frame and still rounds; without it an early s_last aborts to DONE.
module pu_row_loader
    import img2col_pkg::*;
#(
    parameter int ROW         = ROW_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDRESS_NUM = ADDRESS_NUM_DEF,
    parameter int REG_NUM     = REG_NUM_DEF,
    parameter int SHIFTS      = SHIFTS_DEF
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   go,
    pu_row_loader_if.slave         s_if,
    output logic [ROW-1:0]         start,
    output logic [ROW-1:0]         round,
    output logic [DATA_WIDTH-1:0]  new1,
    output logic [DATA_WIDTH-1:0]  new2,
    output logic [ADDRESS_NUM-1:0] adrs_in1,
    output logic [ADDRESS_NUM-1:0] adrs_in2,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int SH_W  = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;

    state_e                 state_q, state_d;
    logic [SH_W-1:0]        shift_q, shift_d;
    logic                   err_q, err_d;
    logic                   pad_q, pad_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ROW-1:0]         start_q, start_d;
    logic [ROW-1:0]         round_q, round_d;
    logic [DATA_WIDTH-1:0]  new1_q, new1_d, new2_q, new2_d;
    logic [ADDRESS_NUM-1:0] adrs1_q, adrs1_d, adrs2_q, adrs2_d;

    logic                   s_ready_s, hs_s, wr_s, go_acc_s, cnt_clr_s, frame_last_s;
    logic [ROW_W-1:0]       row_s;
    logic [ADDRESS_NUM-1:0] col_s;

    // While zero-padding the stream is closed; the loader writes on its own.
    assign s_ready_s   = (state_q == LOAD) & ~pad_q;
    assign s_if.s_ready = s_ready_s;
    assign hs_s        = s_if.s_valid & s_ready_s;
    assign wr_s        = (state_q == LOAD) & (hs_s | pad_q);
    // done_q marks the visible DONE cycle; a go there must not start a frame.
    assign go_acc_s    = go & (state_q == IDLE) & ~done_q;

    pu_addr_cnt #(
        .ROW         (ROW),
        .ADDRESS_NUM (ADDRESS_NUM),
        .REG_NUM     (REG_NUM),
        .ROW_W       (ROW_W)
    ) u_addr_cnt (
        .clk        (clk),
        .nrst       (nrst),
        .clr        (cnt_clr_s),
        .adv        (wr_s),
        .row        (row_s),
        .col        (col_s),
        .frame_last (frame_last_s)
    );

    // State and control registers.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            shift_q <= '0;
            err_q   <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            pad_q   <= pad_d;
        end
    end

    // Next-state logic, framing-error detection and shift counting.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        err_d     = err_q;
        pad_d     = pad_q;
        cnt_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_acc_s) begin
                    state_d   = LOAD;
                    shift_d   = '0;
                    err_d     = 1'b0;
                    pad_d     = 1'b0;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (wr_s && frame_last_s) begin
                    state_d = ROUND;
                    shift_d = '0;
                    // Zero-fill writes already flagged the error; ignore s_last there.
                    if (!pad_q && !s_if.s_last) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else if (wr_s && !pad_q && s_if.s_last) begin
                    err_d = 1'b1;
`ifdef PU_ROW_LOADER_ZERO_PAD_EN
                    pad_d = 1'b1;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
            ROUND: begin
                if (shift_q == SH_W'(SHIFTS - 1)) begin
                    state_d = DONE;
                end else begin
                    shift_d = shift_q + SH_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered output values: write strobe/data on writes, round pulses, status.
    always_comb begin
        start_d = '0;
        new1_d  = new1_q;
        new2_d  = new2_q;
        adrs1_d = adrs1_q;
        adrs2_d = adrs2_q;
        if (wr_s) begin
            start_d = {{(ROW-1){1'b0}}, 1'b1} << row_s;
            new1_d  = pad_q ? '0 : s_if.s_data1;
            new2_d  = pad_q ? '0 : s_if.s_data2;
            adrs1_d = col_s;
            adrs2_d = col_s + ADDRESS_NUM'(1);
        end else begin
            start_d = '0;
        end
        // The output register delays this by one, so the first pulse follows the last strobe.
        round_d = (state_q == ROUND) ? '1 : '0;
        done_d  = (state_q == DONE);
        // Stay busy through the visible done cycle, drop on the one after.
        busy_d  = (state_d != IDLE) | (state_q == DONE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            start_q <= '0;
            round_q <= '0;
            new1_q  <= '0;
            new2_q  <= '0;
            adrs1_q <= '0;
            adrs2_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            round_q <= round_d;
            new1_q  <= new1_d;
            new2_q  <= new2_d;
            adrs1_q <= adrs1_d;
            adrs2_q <= adrs2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign start    = start_q;
    assign round    = round_q;
    assign new1     = new1_q;
    assign new2     = new2_q;
    assign adrs_in1 = adrs1_q;
    assign adrs_in2 = adrs2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
